// File: rtl/padd_sat_pipe.sv
// rtl/padd_sat_pipe.sv - pipelined packed-lane saturating add/subtract unit
// Two-stage valid/ready pipe: S1 holds operands, S2 holds clamped lane results.
module padd_sat_pipe #(
  parameter int LANE_W = 8,
  parameter int LANES  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANE_W*LANES-1:0]  in_a,
  input  logic [LANE_W*LANES-1:0]  in_b,
  input  logic [1:0]               in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANE_W*LANES-1:0]  out_data,
  output logic [LANES-1:0]         out_sat,
  output logic [LANES-1:0]         sat_sticky,
  input  logic                     clr_sticky
);

  localparam int DATA_W = LANE_W * LANES;
  localparam int MSB    = LANE_W - 1;

  logic              r_s1_v;
  logic [DATA_W-1:0] r_s1_a;
  logic [DATA_W-1:0] r_s1_b;
  logic [1:0]        r_s1_op;
  logic              r_s2_v;
  logic [DATA_W-1:0] r_out_data;
  logic [LANES-1:0]  r_out_sat;
  logic [LANES-1:0]  r_sticky;

  logic              w_s2_load;
  logic              w_s1_load;
  logic              w_xfer;
  logic [DATA_W-1:0] w_res;
  logic [LANES-1:0]  w_sat;

  // Returns {saturated, lane result}; lane math is one bit wider than the lane.
  function automatic logic [LANE_W:0] lane_op(
    input logic [LANE_W-1:0] a,
    input logic [LANE_W-1:0] b,
    input logic [1:0]        op
  );
    logic [LANE_W:0]   ea;
    logic [LANE_W:0]   eb;
    logic [LANE_W:0]   s;
    logic              ovf;
    logic [LANE_W-1:0] r;
    ea = op[1] ? {1'b0, a} : {a[MSB], a};
    eb = op[1] ? {1'b0, b} : {b[MSB], b};
    s  = op[0] ? (ea - eb) : (ea + eb);
    if (op[1])
      ovf = s[LANE_W];
    else if (op[0])
      ovf = (a[MSB] != b[MSB]) && (s[MSB] != a[MSB]);
    else
      ovf = (a[MSB] == b[MSB]) && (s[MSB] != a[MSB]);
    r = s[LANE_W-1:0];
    if (ovf) begin
      if (op[1])
        r = op[0] ? '0 : '1;
      else
        r = a[MSB] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
    end
    return {ovf, r};
  endfunction

  always_comb begin
    w_res = '0;
    w_sat = '0;
    for (int i = 0; i < LANES; i++) begin
      {w_sat[i], w_res[i*LANE_W +: LANE_W]} =
        lane_op(r_s1_a[i*LANE_W +: LANE_W], r_s1_b[i*LANE_W +: LANE_W], r_s1_op);
    end
  end

  assign w_s2_load = !r_s2_v || out_ready;
  assign w_s1_load = !r_s1_v || w_s2_load;
  assign w_xfer    = r_s2_v && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v     <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
      r_s2_v     <= 1'b0;
      r_out_data <= '0;
      r_out_sat  <= '0;
      r_sticky   <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_v <= in_valid;
        if (in_valid) begin
          r_s1_a  <= in_a;
          r_s1_b  <= in_b;
          r_s1_op <= in_op;
        end
      end
      // Results only move when S1 has a beat, so out_data holds its last value when empty.
      if (w_s2_load) begin
        r_s2_v <= r_s1_v;
        if (r_s1_v) begin
          r_out_data <= w_res;
          r_out_sat  <= w_sat;
        end
      end
      if (clr_sticky)
        r_sticky <= w_xfer ? r_out_sat : '0;
      else if (w_xfer)
        r_sticky <= r_sticky | r_out_sat;
    end
  end

  assign in_ready   = w_s1_load;
  assign out_valid  = r_s2_v;
  assign out_data   = r_out_data;
  assign out_sat    = r_out_sat;
  assign sat_sticky = r_sticky;

endmodule
